// File: rtl/axi_pkg.sv
// Shared constants and FSM encodings for the SRAM-to-AXI3 bridge.
package axi_pkg;

  localparam logic [3:0] ID_INST    = 4'd0;
  localparam logic [3:0] ID_DATA    = 4'd1;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'd2;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_WAIT = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_SEND = 2'd1,
    W_B    = 2'd2
  } wr_state_t;

endpackage

// File: rtl/axi_wr_ctrl.sv
// Write-side sequencer: registers one data write, drives AW and W independently,
// then waits for the B response.
//
// state  | meaning
// W_IDLE | no write in flight, may accept
// W_SEND | AW and W each held until their own handshake
// W_B    | both sent, waiting for the write response
module axi_wr_ctrl
  import axi_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        accept,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic        idle,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  wr_state_t state, state_nxt;
  logic      aw_done, w_done;
  logic      aw_hs, w_hs;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= W_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      W_IDLE:  if (accept) state_nxt = W_SEND;
      W_SEND:  if ((aw_done | aw_hs) & (w_done | w_hs)) state_nxt = W_B;
      W_B:     if (bvalid & bready) state_nxt = W_IDLE;
      default: state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    idle    = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    case (state)
      W_IDLE: idle = 1'b1;
      W_SEND: begin
        awvalid = ~aw_done;
        wvalid  = ~w_done;
      end
      W_B:     bready = 1'b1;
      default: ;
    endcase
  end

  // Per-channel done flags let AW and W complete in either order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      awaddr  <= '0;
      awsize  <= '0;
      wdata   <= '0;
      wstrb   <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state == W_IDLE && accept) begin
      awaddr  <= req_addr;
      awsize  <= {1'b0, req_size};
      wdata   <= req_wdata;
      wstrb   <= req_wstrb;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state == W_SEND) begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

endmodule

// File: rtl/sram_axi_bridge.sv
// Bridges the instruction-fetch and data SRAM-style ports onto one AXI3 master,
// with data reads winning arbitration and one data transaction in flight.
//
// state  | meaning
// R_IDLE | no read in flight, may accept inst or data read
// R_AR   | arvalid held with captured address until arready
// R_WAIT | rready high, waiting for the single R beat
module sram_axi_bridge
  import axi_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,

  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,

  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,

  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  rd_state_t   r_state, r_state_nxt;
  logic        data_busy;
  logic [31:0] ar_addr_q;
  logic [2:0]  ar_size_q;
  logic [3:0]  ar_id_q;
  logic        r_idle, wr_idle;
  logic        data_rd_req, data_rd_acc, data_wr_acc, inst_acc, rd_acc;
  logic        r_hs, b_hs;
  logic        unused_resp;

  assign unused_resp = ^{rresp, rlast, bid, bresp};

  // Acceptance is gated by resetn so no addr_ok can escape while reset is held.
  assign r_idle      = (r_state == R_IDLE);
  assign data_rd_req = data_req & ~data_wr & ~data_busy;
  assign data_rd_acc = resetn & data_rd_req & r_idle;
  assign data_wr_acc = resetn & data_req & data_wr & wr_idle & ~data_busy;
  assign inst_acc    = resetn & inst_req & r_idle & ~data_rd_req;
  assign rd_acc      = data_rd_acc | inst_acc;

  assign data_addr_ok = data_rd_acc | data_wr_acc;
  assign inst_addr_ok = inst_acc;

  assign r_hs         = rvalid & rready;
  assign b_hs         = bvalid & bready;
  assign inst_data_ok = r_hs & (rid == ID_INST);
  assign data_data_ok = (r_hs & (rid == ID_DATA)) | b_hs;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= R_IDLE;
    else         r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (rd_acc) r_state_nxt = R_AR;
      R_AR:    if (arvalid & arready) r_state_nxt = R_WAIT;
      R_WAIT:  if (r_hs) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    arvalid = 1'b0;
    rready  = 1'b0;
    case (r_state)
      R_AR:    arvalid = 1'b1;
      R_WAIT:  rready  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_addr_q <= '0;
      ar_size_q <= '0;
      ar_id_q   <= '0;
    end else if (data_rd_acc) begin
      ar_addr_q <= data_addr;
      ar_size_q <= {1'b0, data_size};
      ar_id_q   <= ID_DATA;
    end else if (inst_acc) begin
      ar_addr_q <= inst_addr;
      ar_size_q <= SIZE_WORD;
      ar_id_q   <= ID_INST;
    end
  end

  // Keeps data responses in order: no new data request until the last one's data_ok.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)           data_busy <= 1'b0;
    else if (data_addr_ok) data_busy <= 1'b1;
    else if (data_data_ok) data_busy <= 1'b0;
  end

  assign arid    = ar_id_q;
  assign araddr  = ar_addr_q;
  assign arsize  = ar_size_q;
  assign arlen   = 4'd0;
  assign arburst = BURST_INCR;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign awid    = ID_DATA;
  assign awlen   = 4'd0;
  assign awburst = BURST_INCR;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wid     = ID_DATA;
  assign wlast   = 1'b1;

  axi_wr_ctrl u_wr_ctrl (
    .clk       (clk),
    .resetn    (resetn),
    .accept    (data_wr_acc),
    .req_addr  (data_addr),
    .req_size  (data_size),
    .req_wstrb (data_wstrb),
    .req_wdata (data_wdata),
    .idle      (wr_idle),
    .awaddr    (awaddr),
    .awsize    (awsize),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wvalid    (wvalid),
    .wready    (wready),
    .bvalid    (bvalid),
    .bready    (bready)
  );

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed-plus-random bench for sram_axi_bridge with a word-addressed memory model
// standing in for the AXI slave.
module tb_sram_axi_bridge;

  logic        clk, resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid, arlen, arcache;
  logic [31:0] araddr;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid, awlen, awcache;
  logic [31:0] awaddr;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst, awlock;
  logic        awvalid, awready;
  logic [3:0]  wid, wstrb;
  logic [31:0] wdata;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [31:0] mem [logic [29:0]];

  sram_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a[31:2])) return mem[a[31:2]];
    return {a[31:2], 2'b01} ^ 32'h5A5A_0000;
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [3:0] strb, input logic [31:0] wd);
    logic [31:0] w;
    w = mem_rd(a);
    for (int b = 0; b < 4; b++)
      if (strb[b]) w[8*b +: 8] = wd[8*b +: 8];
    mem[a[31:2]] = w;
  endtask

  // Slave side of one read after acceptance; t0 is the accept cycle.
  task automatic rd_complete(input bit is_data, input logic [31:0] addr, input logic [1:0] sz,
                             input int ar_dly, input int r_dly, input int t0);
    logic [31:0] exp_d;
    logic [3:0]  id;
    logic [2:0]  esz;
    exp_d = mem_rd(addr);
    id    = is_data ? 4'd1 : 4'd0;
    esz   = is_data ? {1'b0, sz} : 3'd2;
    for (int i = 0; i < ar_dly; i++) begin
      #1;
      chk("ar_hold_valid", arvalid, 1);
      chk("ar_hold_addr", araddr, addr);
      step();
    end
    arready = 1'b1;
    #1;
    chk("arvalid", arvalid, 1);
    chk("arid", arid, id);
    chk("araddr", araddr, addr);
    chk("arsize", arsize, esz);
    step();
    arready = 1'b0;
    for (int i = 0; i < r_dly; i++) begin
      #1;
      chk("rready", rready, 1);
      chk("early_data_ok", inst_data_ok | data_data_ok, 0);
      step();
    end
    rid = id; rdata = exp_d; rvalid = 1'b1;
    #1;
    chk("rd_data_ok", is_data ? data_data_ok : inst_data_ok, 1);
    chk("rd_other_ok", is_data ? inst_data_ok : data_data_ok, 0);
    chk("rd_rdata", is_data ? data_rdata : inst_rdata, exp_d);
    chk("rd_latency", cyc - t0 + 1, 3 + ar_dly + r_dly);
    step();
    rvalid = 1'b0;
    #1;
    chk("rd_single_ok", inst_data_ok | data_data_ok, 0);
  endtask

  task automatic do_read(input bit is_data, input logic [31:0] addr, input logic [1:0] sz,
                         input int ar_dly, input int r_dly);
    int t0;
    if (is_data) begin
      data_req = 1'b1; data_wr = 1'b0; data_addr = addr; data_size = sz;
    end else begin
      inst_req = 1'b1; inst_addr = addr;
    end
    #1;
    chk("rd_addr_ok", is_data ? data_addr_ok : inst_addr_ok, 1);
    t0 = cyc;
    step();
    inst_req = 1'b0; data_req = 1'b0;
    rd_complete(is_data, addr, sz, ar_dly, r_dly, t0);
  endtask

  // With pend_rd set, a data read to raddr is held during the write and must stay blocked.
  task automatic do_write(input logic [31:0] addr, input logic [1:0] sz, input logic [3:0] strb,
                          input logic [31:0] wd, input int aw_dly, input int w_dly, input int b_dly,
                          input bit pend_rd, input logic [31:0] raddr);
    int t0, k, mx;
    bit aw_done, w_done;
    data_req = 1'b1; data_wr = 1'b1; data_addr = addr; data_size = sz;
    data_wstrb = strb; data_wdata = wd;
    #1;
    chk("wr_addr_ok", data_addr_ok, 1);
    t0 = cyc;
    step();
    data_req = pend_rd; data_wr = 1'b0; data_addr = raddr; data_size = 2'd2;
    data_wstrb = 4'h0; data_wdata = 32'h0;
    aw_done = 1'b0; w_done = 1'b0; k = 0;
    mx = (aw_dly > w_dly) ? aw_dly : w_dly;
    while (!(aw_done && w_done) && k < 40) begin
      awready = !aw_done && (k >= aw_dly);
      wready  = !w_done && (k >= w_dly);
      #1;
      chk("awvalid", awvalid, !aw_done);
      chk("wvalid", wvalid, !w_done);
      if (!aw_done) begin
        chk("awaddr", awaddr, addr);
        chk("awsize", awsize, {1'b0, sz});
      end
      if (!w_done) begin
        chk("wdata", wdata, wd);
        chk("wstrb", wstrb, strb);
        chk("wlast", wlast, 1);
      end
      if (pend_rd) chk("rd_blocked_send", data_addr_ok, 0);
      aw_done = aw_done | awready;
      w_done  = w_done | wready;
      step();
      k++;
    end
    awready = 1'b0; wready = 1'b0;
    mem_wr(addr, strb, wd);
    for (int i = 0; i < b_dly; i++) begin
      #1;
      chk("bready", bready, 1);
      chk("aw_dropped", awvalid | wvalid, 0);
      chk("early_b_ok", data_data_ok, 0);
      if (pend_rd) chk("rd_blocked_b", data_addr_ok, 0);
      step();
    end
    bvalid = 1'b1; bid = 4'd1;
    #1;
    chk("wr_data_ok", data_data_ok, 1);
    chk("wr_latency", cyc - t0 + 1, 3 + mx + b_dly);
    if (pend_rd) chk("rd_blocked_bhs", data_addr_ok, 0);
    step();
    bvalid = 1'b0;
    #1;
    chk("wr_single_ok", data_data_ok, 0);
    if (pend_rd) chk("rd_released", data_addr_ok, 1);
  endtask

  initial begin
    logic [31:0] a, b, w;
    int t0;
    resetn = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h0;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0;
    data_wstrb = 4'h0; data_wdata = 32'h0;
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    rid = 4'd0; rdata = 32'h0; rresp = 2'd0; rlast = 1'b1; rvalid = 1'b0;
    bid = 4'd0; bresp = 2'd0; bvalid = 1'b0;

    // Reset state, requests held high
    #2;
    chk("rst_inst_addr_ok", inst_addr_ok, 0);
    chk("rst_data_addr_ok", data_addr_ok, 0);
    chk("rst_valids", {arvalid, awvalid, wvalid}, 0);
    chk("rst_readys", {rready, bready}, 0);
    chk("rst_data_oks", {inst_data_ok, data_data_ok}, 0);
    chk("const_ar", {arlen, arburst, arlock, arcache, arprot}, {4'd0, 2'b01, 2'd0, 4'd0, 3'd0});
    chk("const_aw", {awid, awlen, awburst, awlock, awcache, awprot}, {4'd1, 4'd0, 2'b01, 2'd0, 4'd0, 3'd0});
    chk("const_w", {wid, wlast}, {4'd1, 1'b1});
    step(); step();
    inst_req = 1'b0; data_req = 1'b0;
    resetn = 1'b1;
    step();

    // Boot fetch with arready two cycles late: 5-cycle latency
    mem[32'h1C00_0000 >> 2] = 32'h0280_0000;
    do_read(1'b0, 32'h1C00_0000, 2'd2, 2, 0);
    step();

    // Data read beats a simultaneous fetch; fetch accepted right after R handshake
    a = 32'h1C00_0004;
    inst_req = 1'b1; inst_addr = a;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h80; data_size = 2'd2;
    #1;
    chk("arb_data_ok", data_addr_ok, 1);
    chk("arb_inst_blocked", inst_addr_ok, 0);
    t0 = cyc;
    step();
    data_req = 1'b0;
    #1;
    chk("arb_inst_wait_ar", inst_addr_ok, 0);
    rd_complete(1'b1, 32'h80, 2'd2, 0, 0, t0);
    chk("arb_inst_after_r", inst_addr_ok, 1);
    t0 = cyc;
    step();
    inst_req = 1'b0;
    rd_complete(1'b0, a, 2'd2, 1, 0, t0);
    step();

    // Byte write, W ready before AW
    do_write(32'h103, 2'd0, 4'b1000, 32'hAB00_0000 | ($urandom & 32'h00FF_FFFF), 2, 0, 0, 1'b0, 32'h0);
    step();
    do_read(1'b1, 32'h100, 2'd2, 0, 0);
    step();

    // Long B delay with a data read waiting behind it
    w = $urandom;
    do_write(32'h200, 2'd2, 4'hF, w, 0, 1, 10, 1'b1, 32'h200);
    t0 = cyc;
    step();
    data_req = 1'b0;
    rd_complete(1'b1, 32'h200, 2'd2, 0, 1, t0);
    step();

    // Fetch response and write response land in the same cycle
    a = 32'h1C00_1000; b = 32'h300; w = $urandom;
    inst_req = 1'b1; inst_addr = a;
    data_req = 1'b1; data_wr = 1'b1; data_addr = b; data_size = 2'd2;
    data_wstrb = 4'hF; data_wdata = w;
    #1;
    chk("co_inst_addr_ok", inst_addr_ok, 1);
    chk("co_data_addr_ok", data_addr_ok, 1);
    step();
    inst_req = 1'b0; data_req = 1'b0;
    arready = 1'b1; awready = 1'b1; wready = 1'b1;
    #1;
    chk("co_valids", {arvalid, awvalid, wvalid}, 3'b111);
    chk("co_arid", arid, 0);
    chk("co_awaddr", awaddr, b);
    chk("co_wdata", wdata, w);
    step();
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    mem_wr(b, 4'hF, w);
    rvalid = 1'b1; rid = 4'd0; rdata = mem_rd(a); bvalid = 1'b1; bid = 4'd1;
    #1;
    chk("co_both_ok", {inst_data_ok, data_data_ok}, 2'b11);
    chk("co_inst_rdata", inst_rdata, mem_rd(a));
    step();
    rvalid = 1'b0; bvalid = 1'b0;
    step();

    // Random mix of reads and writes
    for (int n = 0; n < 10; n++) begin
      a = $urandom & 32'h0000_FFFC;
      if ($urandom_range(1) == 1)
        do_write(a | ($urandom & 32'h3), 2'($urandom_range(2)), 4'($urandom), $urandom,
                 $urandom_range(3), $urandom_range(3), $urandom_range(3), 1'b0, 32'h0);
      else
        do_read(1'($urandom_range(1)), a, 2'($urandom_range(2)), $urandom_range(3), $urandom_range(3));
      step();
    end

    // Reset dropped mid-write with a data read pending
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h400; data_size = 2'd2;
    data_wstrb = 4'hF; data_wdata = $urandom;
    #1;
    chk("rst_wr_accept", data_addr_ok, 1);
    step();
    data_wr = 1'b0;
    #1;
    chk("rst_pre_valids", {awvalid, wvalid}, 2'b11);
    chk("rst_pre_addr_ok", data_addr_ok, 0);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_async_valids", {awvalid, wvalid}, 0);
    chk("rst_async_addr_ok", data_addr_ok, 0);
    step(); step();
    data_req = 1'b0;
    resetn = 1'b1;
    #1;
    chk("rst_post_valids", {arvalid, awvalid, wvalid, bready}, 0);
    step();
    do_read(1'b0, 32'h1C00_2000, 2'd2, 0, 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
